// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch front end.
// The PC advances by STEP once every DIVIDE clocks (the "update slot").
// Redirects arriving off-slot or while stalled are held in a single
// buffer (latest wins) and consumed at the next unstalled slot.
// Optional feature macro: PC_ALIGN_CHECK_EN -- rejects redirect targets
// that are not STEP-aligned at the consuming edge and pulses misaligned.
module pc_sequencer #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                 STEP         = 4,
  parameter int                 DIVIDE       = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             load,
  input  logic [WIDTH-1:0] load_address,
  output logic [WIDTH-1:0] address_out,
  output logic [WIDTH-1:0] address_next,
  output logic             tick,
  output logic             load_pending,
  output logic             misaligned
);

  localparam int              PW      = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [PW-1:0]   PH_LAST = PW'(DIVIDE - 1);
  localparam logic [WIDTH-1:0] INC    = WIDTH'(STEP);

  logic [WIDTH-1:0] pc;
  logic [PW-1:0]    phase;
  logic             pending_valid;
  logic [WIDTH-1:0] pending_addr;

  logic             req_valid;
  logic [WIDTH-1:0] req_addr;
  logic             req_bad;
  logic             slot;

  assign tick         = (phase == '0);
  assign slot         = tick & ~stall;
  assign address_out  = pc;
  assign address_next = pc + INC;
  assign load_pending = pending_valid;

  // A live load always overrides the buffered redirect.
  assign req_valid = load | pending_valid;
  assign req_addr  = load ? load_address : pending_addr;

`ifdef PC_ALIGN_CHECK_EN
  // Low log2(STEP) bits must be zero; with STEP=1 the mask is empty.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  logic misaligned_q;

  assign req_bad    = |(req_addr & ALIGN_MASK);
  assign misaligned = misaligned_q;

  // Rejection flag: one-cycle pulse after a consuming edge drops a target.
  always_ff @(posedge clock) begin
    if (reset) misaligned_q <= 1'b0;
    else       misaligned_q <= slot & req_valid & req_bad;
  end
`else
  assign req_bad    = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Slot phase counter: free-running, ignores stall and load.
  always_ff @(posedge clock) begin
    if (reset)                phase <= '0;
    else if (phase == PH_LAST) phase <= '0;
    else                      phase <= phase + 1'b1;
  end

  // PC update and redirect buffer: update at an unstalled slot, otherwise capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      pending_valid <= 1'b0;
      pending_addr  <= '0;
    end else if (slot) begin
      pending_valid <= 1'b0;
      if (req_valid && !req_bad) pc <= req_addr;
      else                       pc <= pc + INC;
    end else if (load) begin
      pending_valid <= 1'b1;
      pending_addr  <= load_address;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer at default parameters.
// Each driven cycle pushes the expected post-edge state; after the edge the
// entry is popped and compared against the DUT outputs.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset, stall, load;
  logic [31:0] load_address;
  logic [31:0] address_out, address_next;
  logic        tick, load_pending, misaligned;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        tick;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  pc_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .load         (load),
    .load_address (load_address),
    .address_out  (address_out),
    .address_next (address_next),
    .tick         (tick),
    .load_pending (load_pending),
    .misaligned   (misaligned)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the expected post-edge state, then pop and compare.
  task automatic cyc(input logic r, input logic s, input logic l, input logic [31:0] la,
                     input logic [31:0] e_pc, input logic e_pend, input logic e_tick,
                     input logic e_mis, input string tag);
    exp_t e;
    reset = r; stall = s; load = l; load_address = la;
    e.pc = e_pc; e.pend = e_pend; e.tick = e_tick; e.mis = e_mis;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"},   address_out,  e.pc);
    chk({tag, ".next"}, address_next, e.pc + 32'd4);
    chk({tag, ".pend"}, {31'd0, load_pending}, {31'd0, e.pend});
    chk({tag, ".tick"}, {31'd0, tick},         {31'd0, e.tick});
    chk({tag, ".mis"},  {31'd0, misaligned},   {31'd0, e.mis});
  endtask

  // Four idle cycles from phase 1 ending in a tick cycle (phase 0).
  task automatic idle4(input logic [31:0] e_pc, input logic e_pend, input string tag);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, e_pc, e_pend, (i == 3), 0, tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; load = 1'b0; load_address = '0;

    // Reset held two clocks
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 0, "rst0");
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 0, "rst1");

    // Sequential advance: slots at edges 1, 6, 11
    cyc(0, 0, 0, 32'h0, 32'h4, 0, 0, 0, "seq_e1");
    idle4(32'h4, 0, "seq_a");
    cyc(0, 0, 0, 32'h0, 32'h8, 0, 0, 0, "seq_e6");
    idle4(32'h8, 0, "seq_b");
    cyc(0, 0, 0, 32'h0, 32'hC, 0, 0, 0, "seq_e11");

    // Buffered redirect, latest wins (phase 1 then phase 3)
    cyc(0, 0, 1, 32'h100, 32'hC, 1, 0, 0, "buf_ld1");
    cyc(0, 0, 0, 32'h0,   32'hC, 1, 0, 0, "buf_p2");
    cyc(0, 0, 1, 32'h200, 32'hC, 1, 0, 0, "buf_ld2");
    cyc(0, 0, 0, 32'h0,   32'hC, 1, 1, 0, "buf_p4");
    cyc(0, 0, 0, 32'h0,   32'h200, 0, 0, 0, "buf_slot");
    idle4(32'h200, 0, "buf_wait");
    cyc(0, 0, 0, 32'h0,   32'h204, 0, 0, 0, "buf_seq");

    // Immediate redirect in a tick cycle
    idle4(32'h204, 0, "imm_wait");
    cyc(0, 0, 1, 32'h0040_0020, 32'h0040_0020, 0, 0, 0, "imm");

    // Stall across two slots with PC=0x10; load at a stalled slot stays pending
    idle4(32'h0040_0020, 0, "stl_pre");
    cyc(0, 0, 1, 32'h10, 32'h10, 0, 0, 0, "stl_pc10");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, (i == 4), 32'h80, 32'h10, (i >= 4), (i == 3 || i == 8), 0, "stl_hold");
    idle4(32'h10, 1, "stl_rel");
    cyc(0, 0, 0, 32'h0, 32'h80, 0, 0, 0, "stl_slot");

    // Wrap modulo 2^32
    idle4(32'h80, 0, "wrap_pre");
    cyc(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0, "wrap_ld");
    idle4(32'hFFFF_FFFC, 0, "wrap_wait");
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, "wrap");

    // Reset mid-interval with pending redirect; load during reset is discarded
    cyc(0, 0, 1, 32'h300, 32'h0, 1, 0, 0, "mrst_ld");
    cyc(1, 0, 1, 32'h500, 32'h0, 0, 1, 0, "mrst");
    cyc(0, 0, 0, 32'h0,   32'h4, 0, 0, 0, "mrst_rel");

    // Misaligned redirect at a slot with PC=0x40
    idle4(32'h4, 0, "mis_pre");
    cyc(0, 0, 1, 32'h40, 32'h40, 0, 0, 0, "mis_pc40");
    idle4(32'h40, 0, "mis_wait");
`ifdef PC_ALIGN_CHECK_EN
    cyc(0, 0, 1, 32'h0040_0022, 32'h44, 0, 0, 1, "mis_rej");
    cyc(0, 0, 0, 32'h0,         32'h44, 0, 0, 0, "mis_clr");
`else
    cyc(0, 0, 1, 32'h0040_0022, 32'h0040_0022, 0, 0, 0, "mis_ld");
    cyc(0, 0, 0, 32'h0,         32'h0040_0022, 0, 0, 0, "mis_hold");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
